// File: rtl/iq_demod_pkg.sv
// Shared types and width helper for the fs/4 quadrature demodulator.
package iq_demod_pkg;

    typedef enum logic [1:0] {
        PH_I_POS,
        PH_Q_POS,
        PH_I_NEG,
        PH_Q_NEG
    } phase_t;

    typedef enum logic [2:0] {
        ACC_HOLD,
        ACC_CLR,
        ACC_LOAD,
        ACC_LOAD_NEG,
        ACC_ADD,
        ACC_SUB
    } acc_op_t;

    // Exact width of a block sum: N/4 positive and N/4 negative full-scale terms.
    function automatic int calc_owidth(input int width, input int log2n);
        return width + log2n - 1;
    endfunction

endpackage

// File: rtl/iq_demod_acc.sv
// Single signed accumulator with clear/load/negated-load/add/sub/hold control.
// Exposes the next-state sum so a block can be closed on its last sample.
module iq_acc
    import iq_demod_pkg::*;
#(
    parameter int W = 11
) (
    input  logic                clk,
    input  logic                reset,
    input  acc_op_t             op_i,
    input  logic signed [W-1:0] din_i,
    output logic signed [W-1:0] acc_next_o
);

    logic signed [W-1:0] acc_q;
    logic signed [W-1:0] acc_d;

    always_comb begin
        acc_d = acc_q;
        case (op_i)
            ACC_CLR:      acc_d = '0;
            ACC_LOAD:     acc_d = din_i;
            ACC_LOAD_NEG: acc_d = -din_i;
            ACC_ADD:      acc_d = acc_q + din_i;
            ACC_SUB:      acc_d = acc_q - din_i;
            default:      acc_d = acc_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) acc_q <= '0;
        else       acc_q <= acc_d;
    end

    assign acc_next_o = acc_d;

endmodule

// File: rtl/iq_demod.sv
// fs/4 quadrature demodulator: mixes by 1,0,-1,0 / 0,1,0,-1 and sums blocks of 2^LOG2N samples.
// Optional clip flag enabled by defining IQ_DEMOD_CLIP_EN.
module iq_demod
    import iq_demod_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int LOG2N = 4,
    localparam int OWIDTH = calc_owidth(WIDTH, LOG2N)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [WIDTH-1:0]  sink,
    input  logic                     sink_valid,
    input  logic                     sink_sync,
    output logic signed [OWIDTH-1:0] source_x,
    output logic signed [OWIDTH-1:0] source_y,
    output logic                     source_valid,
    output logic                     source_clip
);

    localparam logic [LOG2N-1:0] CNT_LAST = '1;

    phase_t            phase_q, phase_d, eff_phase;
    logic [1:0]        phase_inc;
    logic [LOG2N-1:0]  cnt_q, cnt_d;
    logic              first;
    logic              blk_done;
    acc_op_t           x_op, y_op, skip_op;
    logic signed [OWIDTH-1:0] s_ext;
    logic signed [OWIDTH-1:0] x_next, y_next;
    logic signed [OWIDTH-1:0] src_x_q, src_y_q;
    logic              src_valid_q;

    assign s_ext     = {{(OWIDTH-WIDTH){sink[WIDTH-1]}}, sink};
    // A synced sample is always the first of a fresh block at phase 0.
    assign eff_phase = sink_sync ? PH_I_POS : phase_q;
    assign first     = sink_sync || (cnt_q == '0);
    assign skip_op   = first ? ACC_CLR : ACC_HOLD;
    assign phase_inc = eff_phase + 2'd1;

    always_comb begin
        phase_d  = phase_q;
        cnt_d    = cnt_q;
        x_op     = ACC_HOLD;
        y_op     = ACC_HOLD;
        blk_done = 1'b0;
        if (sink_valid) begin
            phase_d  = phase_t'(phase_inc);
            cnt_d    = sink_sync ? LOG2N'(1) : cnt_q + 1'b1;
            blk_done = !sink_sync && (cnt_q == CNT_LAST);
            case (eff_phase)
                PH_I_POS: begin x_op = first ? ACC_LOAD : ACC_ADD;     y_op = skip_op; end
                PH_Q_POS: begin y_op = first ? ACC_LOAD : ACC_ADD;     x_op = skip_op; end
                PH_I_NEG: begin x_op = first ? ACC_LOAD_NEG : ACC_SUB; y_op = skip_op; end
                PH_Q_NEG: begin y_op = first ? ACC_LOAD_NEG : ACC_SUB; x_op = skip_op; end
                default:  begin x_op = ACC_HOLD;                       y_op = ACC_HOLD; end
            endcase
        end else if (sink_sync) begin
            phase_d = PH_I_POS;
            cnt_d   = '0;
        end
    end

    iq_acc #(.W(OWIDTH)) u_acc_x (
        .clk        (clk),
        .reset      (reset),
        .op_i       (x_op),
        .din_i      (s_ext),
        .acc_next_o (x_next)
    );

    iq_acc #(.W(OWIDTH)) u_acc_y (
        .clk        (clk),
        .reset      (reset),
        .op_i       (y_op),
        .din_i      (s_ext),
        .acc_next_o (y_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q     <= PH_I_POS;
            cnt_q       <= '0;
            src_x_q     <= '0;
            src_y_q     <= '0;
            src_valid_q <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            src_valid_q <= blk_done;
            if (blk_done) begin
                src_x_q <= x_next;
                src_y_q <= y_next;
            end
        end
    end

    assign source_x     = src_x_q;
    assign source_y     = src_y_q;
    assign source_valid = src_valid_q;

`ifdef IQ_DEMOD_CLIP_EN
    localparam logic signed [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH-1:0] S_MAX = {1'b0, {(WIDTH-1){1'b1}}};

    logic clip_q, clip_d, src_clip_q, extreme;

    assign extreme = (sink == S_MIN) || (sink == S_MAX);

    always_comb begin
        clip_d = clip_q;
        if (sink_valid)     clip_d = (first ? 1'b0 : clip_q) | extreme;
        else if (sink_sync) clip_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clip_q     <= 1'b0;
            src_clip_q <= 1'b0;
        end else begin
            clip_q <= clip_d;
            if (blk_done) src_clip_q <= clip_d;
        end
    end

    assign source_clip = src_clip_q;
`else
    assign source_clip = 1'b0;
`endif

endmodule
